dmem_responder: RTL

- Memory-side responder that serves the processor core's data load/store requests.
- Valid/ready request channel in; valid/ready response channel out; word-organised RAM inside.
- Configurable wait states so the core's stall path can be exercised.
- Performs byte-lane alignment, checks alignment and range, and reports errors rather than corrupting memory.

---
 rtl/mem_pkg.sv | 54 +++++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the data-memory responder.
//   mem_size_e : access size encoding as driven on req_size_i (2'b11 is illegal)
//   state_e    : responder FSM states
//   byte_mask  : byte-write enables for a size/lane pair
//   is_aligned : natural-alignment check for a size/lane pair
//   load_mask  : zero-extension mask for right-justified load data
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      MEM_BYTE: m = 4'b0001 << lane;
      MEM_HALF: m = 4'b0011 << lane;
      MEM_WORD: m = 4'b1111;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      MEM_BYTE: ok = 1'b1;
      MEM_HALF: ok = (lane[0] == 1'b0);
      MEM_WORD: ok = (lane == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] load_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      MEM_BYTE: m = 32'h0000_00FF;
      MEM_HALF: m = 32'h0000_FFFF;
      MEM_WORD: m = 32'hFFFF_FFFF;
      default:  m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-wide single-port RAM, four byte-write enables, registered read.
//   clk_i   : clock
//   en_i    : access strobe; read and (masked) write happen only when high
//   we_i    : per-byte write enables, bit b writes wdata_i[8b+7:8b]
//   addr_i  : word index
//   wdata_i : write data, already lane-aligned
//   rdata_o : word read at the last enabled edge (old contents on a write)
// Storage is intentionally not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write and registered read on an enabled edge.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data load/store port.
//   clk_i, reset_ni            : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  : request handshake
//   req_write_i, req_size_i    : store flag, access size (mem_size_e)
//   req_addr_i, req_wdata_i    : byte address, right-justified store data
//   resp_valid_o / resp_ready_i: response handshake
//   resp_rdata_o               : right-justified, zero-extended load data
//   resp_err_o                 : misaligned, illegal size or out-of-range access
// A request is captured in IDLE, waits WAIT_STATES cycles, and the array is
// accessed exactly once on the edge entering RESP. Erroneous accesses never write.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        accept_s, enter_resp_s, resp_hs_s;
  logic        eff_wr_s;
  logic [1:0]  eff_size_s;
  logic [31:0] eff_addr_s, eff_wdata_s;
  logic [31:0] offset_s;
  logic [1:0]  lane_s;
  logic        bad_s;
  logic [3:0]  arr_we_s;
  logic [31:0] arr_wdata_s, arr_rdata_s;

  assign accept_s     = req_valid_i && (state_q == IDLE);
  assign resp_hs_s    = (state_q == RESP) && resp_ready_i;
  assign enter_resp_s = (state_d == RESP) && (state_q != RESP);

  // Select live inputs while IDLE (zero-wait entry into RESP on the accept
  // edge), otherwise the captured request, so later input changes are ignored.
  always_comb begin
    if (state_q == IDLE) begin
      eff_wr_s    = req_write_i;
      eff_size_s  = req_size_i;
      eff_addr_s  = req_addr_i;
      eff_wdata_s = req_wdata_i;
    end else begin
      eff_wr_s    = wr_q;
      eff_size_s  = size_q;
      eff_addr_s  = addr_q;
      eff_wdata_s = wdata_q;
    end
  end

  // Address decode, range/alignment check and store lane alignment.
  always_comb begin
    offset_s    = eff_addr_s - BASE_ADDR;
    lane_s      = offset_s[1:0];
    bad_s       = (eff_addr_s < BASE_ADDR) || (offset_s >= SPAN) ||
                  !is_aligned(eff_size_s, lane_s);
    arr_wdata_s = eff_wdata_s << {lane_s, 3'b000};
    if (eff_wr_s && !bad_s) begin
      arr_we_s = byte_mask(eff_size_s, lane_s);
    end else begin
      arr_we_s = 4'b0000;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (enter_resp_s),
    .we_i    (arr_we_s),
    .addr_i  (offset_s[AW+1:2]),
    .wdata_i (arr_wdata_s),
    .rdata_o (arr_rdata_s)
  );

  // State, wait counter, captured request and error flag registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q + 4'd1 == WS) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture on accept; error flag latched at RESP entry, cleared on handshake.
  always_comb begin
    if (accept_s) begin
      wr_d    = req_write_i;
      size_d  = req_size_i;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
    end else begin
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
    end
    if (enter_resp_s) begin
      err_d = bad_s;
    end else if (resp_hs_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Outputs; in RESP the decode path sees the captured request, so lane_s
  // is the lane of the transaction being answered.
  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    resp_err_o   = (state_q == RESP) && err_q;
    if ((state_q == RESP) && !err_q && !wr_q) begin
      resp_rdata_o = (arr_rdata_s >> {lane_s, 3'b000}) & load_mask(size_q);
    end else begin
      resp_rdata_o = 32'h0000_0000;
    end
  end

endmodule
